noc_rr_arbiter: RTL and testbench

Parametrised output-port arbiter for the NoC router. It generalises the fixed five-input arbiter to `NUM_PORTS` requesters and uses a rotating round-robin pointer with sticky grants. A `MAX_HOLD` fairness limit bounds how long one input can keep the port, and optional packet locking holds the grant until a tail flit. It drives the crossbar select and runs the RTS/DCTS flit handshake toward the downstream buffer.

---
 rtl/noc_arb_pkg.sv | 27 ++
 rtl/noc_rr_arbiter_if.sv | 43 ++++
 rtl/noc_rr_arbiter_rr_picker.sv | 42 ++++
 rtl/noc_rr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_noc_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_arb_pkg.sv
// -----------------------------------------------------------------------------
// noc_arb_pkg
// Shared definitions for the NoC output-port round-robin arbiter:
//   - arbiter state encoding (legacy-compatible constants plus the enum type)
//   - port-index constants for the five-port router (Local, N, E, W, S)
// -----------------------------------------------------------------------------
package noc_arb_pkg;

  // Raw state codes, kept as plain constants for legacy code that compares bits
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    GAP  = ST_GAP
  } arb_state_t;

  // Requester indices of the five-port router
  localparam int unsigned PORT_L = 32'd0;
  localparam int unsigned PORT_N = 32'd1;
  localparam int unsigned PORT_E = 32'd2;
  localparam int unsigned PORT_W = 32'd3;
  localparam int unsigned PORT_S = 32'd4;

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter_if
// Request / flit-handshake bundle between the router inputs, the arbiter and
// the downstream buffer.
//   Req      requester -> arbiter   per-input request level
//   Tail     requester -> arbiter   per-input "current flit is tail"
//   DCTS     downstream -> arbiter  clear-to-send
//   RTS      arbiter -> downstream  request-to-send (registered)
//   Grant    arbiter -> requester   one-hot handshake strobe
//   Xbar_sel arbiter -> crossbar    one-hot crossbar select
// Modports: master = environment side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface noc_rr_arbiter_if #(
  parameter int NUM_PORTS = 5
);
  import noc_arb_pkg::*;

  logic [NUM_PORTS-1:0] Req;
  logic [NUM_PORTS-1:0] Tail;
  logic                 DCTS;
  logic                 RTS;
  logic [NUM_PORTS-1:0] Grant;
  logic [NUM_PORTS-1:0] Xbar_sel;

  modport master (
    output Req,
    output Tail,
    output DCTS,
    input  RTS,
    input  Grant,
    input  Xbar_sel
  );

  modport slave (
    input  Req,
    input  Tail,
    input  DCTS,
    output RTS,
    output Grant,
    output Xbar_sel
  );

endinterface

// File: rtl/noc_rr_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: returns the first requesting index found
// scanning start, start+1, ... modulo NUM_PORTS.
//   req     in   NUM_PORTS  request vector
//   start   in   IDX_W      first index examined
//   winner  out  NUM_PORTS  one-hot winner (0 when nothing requests)
//   valid   out  1          at least one request present
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_PORTS = 5,
  parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [NUM_PORTS-1:0] winner,
  output logic                 valid
);

  // Scan the rotated order; the first hit wins and masks later candidates
  always_comb begin : scan
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(start) + i;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end else begin
        idx = idx;
      end
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
// Output-port arbiter for the NoC router: rotating round-robin pointer with
// sticky grants, a MAX_HOLD fairness limit, and an RTS/DCTS flit handshake
// toward the downstream buffer. After each handshake RTS drops for one GAP
// cycle while the crossbar select settles on the next owner.
//   clk   in     clock
//   rst   in     asynchronous active-low reset
//   bus   slave  Req/Tail/DCTS in, RTS/Grant/Xbar_sel out
// Parameters: NUM_PORTS (>=2), MAX_HOLD (0 = unlimited hold).
// Optional build macro NOC_ARB_PKT_LOCK_EN: a non-tail handshake locks the
// port to its current owner until a handshake carrying Tail.
// -----------------------------------------------------------------------------
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int MAX_HOLD  = 4
) (
  input  logic            clk,
  input  logic            rst,
  noc_rr_arbiter_if.slave bus
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  arb_state_t           state_r, state_s;
  logic [NUM_PORTS-1:0] sel_r, sel_s;
  logic [IDX_W-1:0]     ptr_r, ptr_s;
  logic [HOLD_W-1:0]    hold_cnt_r, hold_cnt_s;
  logic                 rts_r, rts_s;

  logic [IDX_W-1:0]     start_s;
  logic [NUM_PORTS-1:0] win_s;
  logic                 win_valid_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic                 handshake_s;
  logic                 cur_req_s;
  logic                 others_s;
  logic                 hold_room_s;
  logic [HOLD_W-1:0]    hold_inc_s;
  logic                 keep_s;

  // ptr always names the last selected input, so ptr+1 serves both the IDLE
  // search and the "current index + 1" search after a handshake.
  assign start_s = (ptr_r == IDX_W'(NUM_PORTS - 1)) ? '0 : ptr_r + IDX_W'(1);

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req    (bus.Req),
    .start  (start_s),
    .winner (win_s),
    .valid  (win_valid_s)
  );

  assign win_idx_s   = onehot_to_idx(win_s);
  assign handshake_s = rts_r & bus.DCTS;
  assign cur_req_s   = |(bus.Req & sel_r);
  assign others_s    = |(bus.Req & ~sel_r);
  assign hold_room_s = (MAX_HOLD == 0) ? 1'b1 : ((int'(hold_cnt_r) + 1) < MAX_HOLD);
  assign hold_inc_s  = (hold_cnt_r == HOLD_SAT) ? hold_cnt_r : hold_cnt_r + HOLD_W'(1);

`ifdef NOC_ARB_PKT_LOCK_EN
  logic tail_s;
  logic lock_r, lock_s;

  assign tail_s = |(bus.Tail & sel_r);

  // Each handshake re-derives the lock from its own flit; otherwise it holds
  always_comb begin
    if (handshake_s) begin
      lock_s = ~tail_s;
    end else begin
      lock_s = lock_r;
    end
  end

  // A locked packet keeps its input regardless of Req and the hold limit
  assign keep_s = lock_s | (cur_req_s & (hold_room_s | ~others_s));

  // Lock register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_r <= 1'b0;
    end else begin
      lock_r <= lock_s;
    end
  end
`else
  assign keep_s = cur_req_s & (hold_room_s | ~others_s);
`endif

  // Next-state and selection logic
  always_comb begin
    state_s    = state_r;
    sel_s      = sel_r;
    ptr_s      = ptr_r;
    hold_cnt_s = hold_cnt_r;
    rts_s      = rts_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          sel_s      = win_s;
          ptr_s      = win_idx_s;
          hold_cnt_s = '0;
          rts_s      = 1'b1;
          state_s    = SEND;
        end else begin
          sel_s      = '0;
          rts_s      = 1'b0;
          state_s    = IDLE;
        end
      end
      SEND: begin
        // Without DCTS everything is frozen, including the effect of Req
        if (handshake_s) begin
          rts_s = 1'b0;
          if (keep_s) begin
            hold_cnt_s = hold_inc_s;
            state_s    = GAP;
          end else if (win_valid_s) begin
            sel_s      = win_s;
            ptr_s      = win_idx_s;
            hold_cnt_s = '0;
            state_s    = GAP;
          end else begin
            sel_s      = '0;
            hold_cnt_s = '0;
            state_s    = IDLE;
          end
        end else begin
          rts_s = 1'b1;
        end
      end
      GAP: begin
        rts_s   = 1'b1;
        state_s = SEND;
      end
      default: begin
        sel_s      = '0;
        hold_cnt_s = '0;
        rts_s      = 1'b0;
        state_s    = IDLE;
      end
    endcase
  end

  // State, selection and handshake registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      sel_r      <= '0;
      ptr_r      <= IDX_W'(NUM_PORTS - 1);
      hold_cnt_r <= '0;
      rts_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      ptr_r      <= ptr_s;
      hold_cnt_r <= hold_cnt_s;
      rts_r      <= rts_s;
    end
  end

  assign bus.RTS      = rts_r;
  assign bus.Xbar_sel = sel_r;
  assign bus.Grant    = sel_r & {NUM_PORTS{rts_r & bus.DCTS}};

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_rr_arbiter
// Self-checking bench for noc_rr_arbiter (NUM_PORTS=5). Directed scenarios
// with hand-computed expectations, then randomized traffic compared every
// cycle against an integer-level reference model of the arbitration rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_noc_rr_arbiter;

  localparam int NP = 5;
`ifdef NOC_ARB_PKT_LOCK_EN
  localparam int MH = 1;
`else
  localparam int MH = 2;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  noc_rr_arbiter_if #(.NUM_PORTS(NP)) bus();

  noc_rr_arbiter #(
    .NUM_PORTS (NP),
    .MAX_HOLD  (MH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the port, whether RTS is up, the last owner
  // (round-robin origin), consecutive keeps, and packet lock.
  bit m_busy;
  bit m_rts;
  int m_cur;
  int m_last;
  int m_run;
  bit m_lock;

  logic [NP-1:0] gq [$];

  bit            lit_on;
  string         lit_name;
  logic          lit_r;
  logic [NP-1:0] lit_g;
  logic [NP-1:0] lit_x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_rts  = 1'b0;
    m_cur  = -1;
    m_last = NP - 1;
    m_run  = 0;
    m_lock = 1'b0;
  endtask

  function automatic int search(input int from, input logic [NP-1:0] r);
    for (int k = 1; k <= NP; k++) begin
      if (r[(from + k) % NP]) return (from + k) % NP;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic model_step();
    int  j;
    bit  keep;
    logic [NP-1:0] others;
    if (rst) begin
      if (!m_busy) begin
        j = search(m_last, bus.Req);
        if (j >= 0) begin
          m_cur = j; m_last = j; m_run = 0; m_busy = 1'b1; m_rts = 1'b1;
        end
      end else if (!m_rts) begin
        m_rts = 1'b1;
      end else if (bus.DCTS) begin
        others = bus.Req;
        others[m_cur] = 1'b0;
        keep = bus.Req[m_cur] && (MH == 0 || m_run + 1 < MH || others == '0);
`ifdef NOC_ARB_PKT_LOCK_EN
        m_lock = !bus.Tail[m_cur];
        keep = keep || m_lock;
`endif
        m_rts = 1'b0;
        if (keep) begin
          m_run++;
        end else begin
          j = search(m_cur, bus.Req);
          if (j >= 0) begin
            m_cur = j; m_last = j; m_run = 0;
          end else begin
            m_busy = 1'b0; m_cur = -1; m_run = 0;
          end
        end
      end
    end
  endtask

  task automatic model_check();
    logic [NP-1:0] ex;
    logic [NP-1:0] eg;
    ex = '0;
    if (m_busy) ex[m_cur] = 1'b1;
    eg = (m_rts && bus.DCTS) ? ex : '0;
    chk("model_rts", bus.RTS, m_rts);
    chk("model_xbar", bus.Xbar_sel, ex);
    chk("model_grant", bus.Grant, eg);
  endtask

  // One clock: check outputs mid-cycle, then step the model at the edge
  task automatic tick();
    @(negedge clk);
    model_check();
    if (lit_on) begin
      chk({lit_name, "_rts"}, bus.RTS, lit_r);
      chk({lit_name, "_grant"}, bus.Grant, lit_g);
      chk({lit_name, "_xbar"}, bus.Xbar_sel, lit_x);
      lit_on = 1'b0;
    end
    if (bus.Grant != '0) gq.push_back(bus.Grant);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick_lit(input string name, input logic r, input logic [NP-1:0] g,
                          input logic [NP-1:0] x);
    lit_on = 1'b1; lit_name = name; lit_r = r; lit_g = g; lit_x = x;
    tick();
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic areset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("areset_rts", bus.RTS, 1'b0);
    chk("areset_grant", bus.Grant, '0);
    chk("areset_xbar", bus.Xbar_sel, '0);
    rst = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] exp_seq [0:6];
    checks = 0; failures = 0; lit_on = 1'b0;
    rst = 1'b0;
    bus.Req = '0; bus.Tail = '1; bus.DCTS = 1'b0;
    model_reset();

    // Reset held with every input requesting
    bus.Req = 5'b11111; bus.DCTS = 1'b1;
    tick_lit("reset_hold", 1'b0, 5'b00000, 5'b00000);
    rst = 1'b1; bus.Req = 5'b00001;
    tick_lit("reset_idle", 1'b0, 5'b00000, 5'b00000);
    tick_lit("first_flit", 1'b1, 5'b00001, 5'b00001);
    tick_lit("first_gap", 1'b0, 5'b00000, 5'b00001);
    tick_lit("second_flit", 1'b1, 5'b00001, 5'b00001);

`ifndef NOC_ARB_PKT_LOCK_EN
    // Fairness with MAX_HOLD=2: two flits per input, rotating 1 -> 2 -> 4 -> 1
    areset();
    bus.Req = 5'b10110; bus.DCTS = 1'b1;
    gq.delete();
    repeat (16) tick();
    exp_seq = '{5'b00010, 5'b00010, 5'b00100, 5'b00100, 5'b10000, 5'b10000, 5'b00010};
    for (int i = 0; i < 7; i++) begin
      chk("fair_order", (i < gq.size()) ? gq[i] : 5'b00000, exp_seq[i]);
    end
`endif

    // Stall: selection frozen while DCTS is low
    areset();
    bus.Req = 5'b00100; bus.DCTS = 1'b0;
    tick_lit("stall_idle", 1'b0, 5'b00000, 5'b00000);
    bus.Req = 5'b01000;
    repeat (3) tick_lit("stall_hold", 1'b1, 5'b00000, 5'b00100);
    bus.DCTS = 1'b1;
    tick_lit("stall_release", 1'b1, 5'b00100, 5'b00100);
    tick_lit("stall_gap", 1'b0, 5'b00000, 5'b01000);
    tick_lit("stall_next", 1'b1, 5'b01000, 5'b01000);

    // Wrap-around from input 4 back to input 0
    areset();
    bus.Req = 5'b10000; bus.DCTS = 1'b1;
    tick();
    bus.Req = 5'b00011;
    tick_lit("wrap_last", 1'b1, 5'b10000, 5'b10000);
    tick_lit("wrap_gap", 1'b0, 5'b00000, 5'b00001);

`ifdef NOC_ARB_PKT_LOCK_EN
    // Packet lock with MAX_HOLD=1: four flits on input 0 despite input 3
    areset();
    bus.Req = 5'b01001; bus.DCTS = 1'b1;
    gq.delete();
    for (int i = 0; i < 12; i++) begin
      bus.Tail = (gq.size() == 3) ? 5'b00001 : 5'b00000;
      tick();
    end
    exp_seq = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b01000, 5'b01000, 5'b01000};
    for (int i = 0; i < 5; i++) begin
      chk("lock_order", (i < gq.size()) ? gq[i] : 5'b00000, exp_seq[i]);
    end
    bus.Tail = '1;
`endif

    // Asynchronous reset in the middle of a SEND with DCTS high
    areset();
    bus.Req = 5'b00001; bus.DCTS = 1'b1;
    tick();
    #1;
    chk("midsend_pre_grant", bus.Grant, 5'b00001);
    rst = 1'b0;
    #1;
    chk("midsend_rts", bus.RTS, 1'b0);
    chk("midsend_grant", bus.Grant, 5'b00000);
    chk("midsend_xbar", bus.Xbar_sel, 5'b00000);
    model_reset();
    rst = 1'b1;
    bus.Req = 5'b00000;
    tick_lit("midsend_idle", 1'b0, 5'b00000, 5'b00000);

    // Randomized traffic against the model
    areset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.Req = NP'($urandom_range(0, 31));
      end
      bus.Tail = NP'($urandom_range(0, 31));
      bus.DCTS = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 299) == 0) areset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
